// File: rtl/bf_bus_pkg.sv
// Shared types, default widths and the strobe decoder for the BF bus responder.
package bf_bus_pkg;

  localparam int DEF_ADDR_WIDTH     = 15;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_OUT_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    Clear   = 3'd0,
    Idle    = 3'd1,
    Access  = 3'd2,
    WaitIn  = 3'd3,
    WaitOut = 3'd4
  } resp_state_t;

  typedef enum logic [2:0] {
    ReqNone   = 3'd0,
    ReqProg   = 3'd1,
    ReqDataRd = 3'd2,
    ReqDataWr = 3'd3,
    ReqIoRd   = 3'd4,
    ReqIoWr   = 3'd5,
    ReqMulti  = 3'd6
  } req_kind_t;

  // Strobe vector order: {write_io, read_io, write_data, read_data, read_prog}.
  function automatic req_kind_t decode_req(input logic [4:0] stb);
    req_kind_t kind;
    case (stb)
      5'b00000: kind = ReqNone;
      5'b00001: kind = ReqProg;
      5'b00010: kind = ReqDataRd;
      5'b00100: kind = ReqDataWr;
      5'b01000: kind = ReqIoRd;
      5'b10000: kind = ReqIoWr;
      default:  kind = ReqMulti;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/bf_out_fifo.sv
// Output byte FIFO with a registered head byte; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module bf_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             r_full;
  logic             r_valid;
  logic [WIDTH-1:0] r_head;

  logic             w_do_push;
  logic             w_do_pop;
  logic [PW-1:0]    w_rptr_nxt;
  logic [PW:0]      w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  always_comb begin
    w_do_pop  = i_pop & r_valid;
    w_do_push = i_push & (~r_full | w_do_pop);
    if (w_do_pop) begin
      w_rptr_nxt = r_rptr + PW'(1);
    end else begin
      w_rptr_nxt = r_rptr;
    end
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + (PW+1)'(1);
      2'b01:   w_count_nxt = r_count - (PW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
    // The new head is the byte being pushed when it lands exactly at the next read slot.
    if (w_do_push && (r_wptr == w_rptr_nxt)) begin
      w_head_nxt = i_push_data;
    end else begin
      w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_valid <= 1'b0;
      r_head  <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (PW+1)'(DEPTH));
      r_valid <= (w_count_nxt != '0);
      r_head  <= w_head_nxt;
    end
  end

  assign o_full  = r_full;
  assign o_valid = r_valid;
  assign o_head  = r_head;

endmodule

// File: rtl/bf_bus_responder.sv
// Target side of the BF core bus: program/data memories, byte I/O and the
// post-reset data-memory clear. Optional macro: BFCHIP_IO_EOF_EN (input EOF release).
module bf_bus_responder
  import bf_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int OUT_FIFO_DEPTH = DEF_OUT_FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] val_out,
  output logic [DATA_WIDTH-1:0] val_in,
  output logic                  valid,
  input  logic                  read_prog,
  input  logic                  read_data,
  input  logic                  write_data,
  input  logic                  read_io,
  input  logic                  write_io,
  output logic                  busy,
  output logic                  proto_err,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_waddr,
  input  logic [DATA_WIDTH-1:0] prog_wdata,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  input  logic                  in_eof
);

  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_dmem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_pmem [MEM_DEPTH];

  resp_state_t           r_state;
  logic [ADDR_WIDTH-1:0] r_clear_cnt;
  logic [DATA_WIDTH-1:0] r_val_in;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_proto_err;
  logic                  r_in_ready;

  req_kind_t             w_kind;
  logic                  w_fifo_full;
  logic                  w_fifo_valid;
  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_push;
  logic                  w_io_eof;
  logic                  w_dmem_we;
  logic [ADDR_WIDTH-1:0] w_dmem_waddr;
  logic [DATA_WIDTH-1:0] w_dmem_wdata;

  assign w_kind = decode_req({write_io, read_io, write_data, read_data, read_prog});

  always_comb begin
`ifdef BFCHIP_IO_EOF_EN
    w_io_eof = in_eof & ~in_valid;
`else
    w_io_eof = 1'b0;
`endif
  end

`ifndef BFCHIP_IO_EOF_EN
  logic w_unused_eof;
  assign w_unused_eof = in_eof;
`endif

  always_comb begin
    w_pop     = out_ready & w_fifo_valid;
    w_push_ok = ~w_fifo_full | w_pop;
    if ((r_state == Idle) && (w_kind == ReqIoWr)) begin
      w_push = w_push_ok;
    end else if (r_state == WaitOut) begin
      w_push = w_push_ok;
    end else begin
      w_push = 1'b0;
    end
  end

  always_comb begin
    if (r_state == Clear) begin
      w_dmem_we    = 1'b1;
      w_dmem_waddr = r_clear_cnt;
      w_dmem_wdata = '0;
    end else if ((r_state == Idle) && (w_kind == ReqDataWr)) begin
      w_dmem_we    = 1'b1;
      w_dmem_waddr = addr;
      w_dmem_wdata = val_out;
    end else begin
      w_dmem_we    = 1'b0;
      w_dmem_waddr = addr;
      w_dmem_wdata = val_out;
    end
  end

  always_ff @(posedge clock) begin
    if (w_dmem_we) begin
      r_dmem[w_dmem_waddr] <= w_dmem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (prog_we) begin
      r_pmem[prog_waddr] <= prog_wdata;
    end
  end

  // valid and in_ready default low so each completion is a single-cycle pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= Clear;
      r_clear_cnt <= '0;
      r_val_in    <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b1;
      r_proto_err <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_in_ready <= 1'b0;
      case (r_state)
        Clear: begin
          r_clear_cnt <= r_clear_cnt + ADDR_WIDTH'(1);
          if (r_clear_cnt == {ADDR_WIDTH{1'b1}}) begin
            r_state <= Idle;
            r_busy  <= 1'b0;
          end
        end
        Idle: begin
          case (w_kind)
            ReqNone: r_state <= Idle;
            ReqProg: begin
              r_val_in <= r_pmem[addr];
              r_valid  <= 1'b1;
              r_state  <= Access;
            end
            ReqDataRd: begin
              r_val_in <= r_dmem[addr];
              r_valid  <= 1'b1;
              r_state  <= Access;
            end
            ReqDataWr: begin
              r_valid <= 1'b1;
              r_state <= Access;
            end
            ReqIoRd: begin
              if (in_valid) begin
                r_in_ready <= 1'b1;
                r_val_in   <= in_data;
                r_valid    <= 1'b1;
                r_state    <= Access;
              end else if (w_io_eof) begin
                r_val_in <= '0;
                r_valid  <= 1'b1;
                r_state  <= Access;
              end else begin
                r_state <= WaitIn;
              end
            end
            ReqIoWr: begin
              if (w_push_ok) begin
                r_valid <= 1'b1;
                r_state <= Access;
              end else begin
                r_state <= WaitOut;
              end
            end
            default: begin
              r_proto_err <= 1'b1;
              r_val_in    <= '0;
              r_valid     <= 1'b1;
              r_state     <= Access;
            end
          endcase
        end
        Access: r_state <= Idle;
        WaitIn: begin
          if (in_valid) begin
            r_in_ready <= 1'b1;
            r_val_in   <= in_data;
            r_valid    <= 1'b1;
            r_state    <= Access;
          end else if (w_io_eof) begin
            r_val_in <= '0;
            r_valid  <= 1'b1;
            r_state  <= Access;
          end
        end
        WaitOut: begin
          if (w_push_ok) begin
            r_valid <= 1'b1;
            r_state <= Access;
          end
        end
        default: r_state <= Idle;
      endcase
    end
  end

  bf_out_fifo #(
    .DEPTH (OUT_FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_out_fifo (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_push      (w_push),
    .i_push_data (val_out),
    .i_pop       (out_ready),
    .o_full      (w_fifo_full),
    .o_valid     (w_fifo_valid),
    .o_head      (out_data)
  );

  assign val_in    = r_val_in;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign proto_err = r_proto_err;
  assign in_ready  = r_in_ready;
  assign out_valid = w_fifo_valid;

endmodule

// File: tb/tb_bf_bus_responder.sv
// Directed bench for bf_bus_responder (8-bit address build to keep the clear sweep short).
module tb_bf_bus_responder;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam logic [4:0] S_RP = 5'b00001;
  localparam logic [4:0] S_RD = 5'b00010;
  localparam logic [4:0] S_WD = 5'b00100;
  localparam logic [4:0] S_RI = 5'b01000;
  localparam logic [4:0] S_WI = 5'b10000;

  typedef struct {
    logic [4:0]    stb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          chk_val;
    logic [DW-1:0] exp_val;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] val_out = '0;
  logic [DW-1:0] val_in;
  logic          valid;
  logic [4:0]    stb = '0;
  logic          busy;
  logic          proto_err;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_waddr = '0;
  logic [DW-1:0] prog_wdata = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          in_eof = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs [10];

  always #5 clock = ~clock;

  bf_bus_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .addr(addr), .val_out(val_out), .val_in(val_in),
    .valid(valid), .read_prog(stb[0]), .read_data(stb[1]), .write_data(stb[2]),
    .read_io(stb[3]), .write_io(stb[4]), .busy(busy), .proto_err(proto_err),
    .prog_we(prog_we), .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .in_eof(in_eof)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request from a negedge; returns at the negedge where valid is seen.
  task automatic req(input logic [4:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     output logic [DW-1:0] rv, output int lat);
    stb = s; addr = a; val_out = d; lat = -1; rv = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (valid) begin
        lat = c;
        rv  = val_in;
        break;
      end
    end
    stb = '0;
  endtask

  task automatic run_clear(input bit do_prog, input bit poke, output int n_busy, output logic vseen);
    n_busy = 0; vseen = 1'b0;
    while (n_busy < 1000) begin
      @(negedge clock);
      n_busy++;
      if (valid) vseen = 1'b1;
      if (do_prog && n_busy == 3) begin
        prog_we = 1'b1; prog_waddr = 8'd3; prog_wdata = 8'h2B;
      end else begin
        prog_we = 1'b0;
      end
      if (poke && n_busy == 1) begin stb = S_RD; addr = 8'd5; end
      if (poke && n_busy == 6) stb = '0;
      if (!busy) break;
    end
  endtask

  initial begin
    int n;
    int lat;
    logic vseen;
    logic [DW-1:0] rv;
    int fifth_at;
    logic [DW-1:0] got [$];

    vecs[0] = '{S_RD, 8'd0,   8'h00, 1'b1, 8'h00};
    vecs[1] = '{S_RD, 8'd5,   8'h00, 1'b1, 8'h00};
    vecs[2] = '{S_RD, 8'd255, 8'h00, 1'b1, 8'h00};
    vecs[3] = '{S_WD, 8'd7,   8'h41, 1'b0, 8'h00};
    vecs[4] = '{S_RD, 8'd7,   8'h00, 1'b1, 8'h41};
    vecs[5] = '{S_WD, 8'd255, 8'h99, 1'b1, 8'h41};
    vecs[6] = '{S_RD, 8'd255, 8'h00, 1'b1, 8'h99};
    vecs[7] = '{S_RP, 8'd3,   8'h00, 1'b1, 8'h2B};
    vecs[8] = '{S_WD, 8'd9,   8'h55, 1'b1, 8'h2B};
    vecs[9] = '{S_RD, 8'd9,   8'h00, 1'b1, 8'h55};

    repeat (2) @(negedge clock);
    check("rst_val_in", 32'(val_in), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_proto_err", 32'(proto_err), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    reset = 1'b0;

    // First sweep, loading '+' into program address 3 while busy.
    run_clear(1'b1, 1'b0, n, vseen);
    check("clear1_busy_cycles", 32'(n), 32'd256);
    check("clear1_no_valid", 32'(vseen), 32'h0);

    foreach (vecs[i]) begin
      req(vecs[i].stb, vecs[i].addr, vecs[i].wdata, rv, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
      if (vecs[i].chk_val) check($sformatf("vec%0d_val_in", i), 32'(rv), 32'(vecs[i].exp_val));
      @(negedge clock);
      check($sformatf("vec%0d_valid_pulse", i), 32'(valid), 32'h0);
    end

    // Same-cycle program load and read_prog of address 3 returns the old byte.
    prog_we = 1'b1; prog_waddr = 8'd3; prog_wdata = 8'h3C;
    req(S_RP, 8'd3, 8'h00, rv, lat);
    prog_we = 1'b0;
    check("prog_same_cycle_old", 32'(rv), 32'h2B);
    @(negedge clock);
    req(S_RP, 8'd3, 8'h00, rv, lat);
    check("prog_new_value", 32'(rv), 32'h3C);
    @(negedge clock);

    // Output FIFO: four writes fill it, the fifth stalls until the first pop.
    for (int b = 1; b <= 4; b++) begin
      req(S_WI, 8'd0, 8'(b), rv, lat);
      check($sformatf("wio%0d_latency", b), 32'(lat), 32'd1);
      @(negedge clock);
    end
    stb = S_WI; val_out = 8'h05; n = 0;
    repeat (5) begin
      @(negedge clock);
      if (valid) n++;
    end
    check("wio5_stalled", 32'(n), 32'd0);
    check("fifo_head_first", 32'(out_data), 32'h01);
    out_ready = 1'b1; fifth_at = -1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) got.push_back(out_data);
      @(negedge clock);
      if (valid && fifth_at < 0) begin
        fifth_at = c;
        stb = '0;
      end
    end
    out_ready = 1'b0;
    check("wio5_valid_after_first_pop", 32'(fifth_at), 32'd0);
    check("fifo_count_out", 32'(got.size()), 32'd5);
    foreach (got[k]) check($sformatf("fifo_order%0d", k), 32'(got[k]), 32'(k + 1));
    check("fifo_empty_after", 32'(out_valid), 32'h0);

    // read_io with no input waits; then one byte completes it.
    stb = S_RI; n = 0;
    repeat (20) begin
      @(negedge clock);
      if (valid || in_ready) n++;
    end
    check("rio_wait_no_valid", 32'(n), 32'd0);
    in_valid = 1'b1; in_data = 8'h7A;
    @(negedge clock);
    check("rio_valid", 32'(valid), 32'h1);
    check("rio_in_ready", 32'(in_ready), 32'h1);
    check("rio_val_in", 32'(val_in), 32'h7A);
    stb = '0; in_valid = 1'b0;
    @(negedge clock);
    check("rio_in_ready_once", 32'(in_ready), 32'h0);
    check("rio_valid_once", 32'(valid), 32'h0);
    in_valid = 1'b1; in_data = 8'h5C;
    req(S_RI, 8'd0, 8'h00, rv, lat);
    check("rio_imm_latency", 32'(lat), 32'd1);
    check("rio_imm_val", 32'(rv), 32'h5C);
    check("rio_imm_in_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b0;
    @(negedge clock);

`ifdef BFCHIP_IO_EOF_EN
    in_eof = 1'b1;
    req(S_RI, 8'd0, 8'h00, rv, lat);
    check("eof_imm_latency", 32'(lat), 32'd1);
    check("eof_imm_val", 32'(rv), 32'h0);
    check("eof_imm_no_in_ready", 32'(in_ready), 32'h0);
    in_eof = 1'b0;
    @(negedge clock);
    stb = S_RI;
    repeat (3) @(negedge clock);
    check("eof_wait_no_valid", 32'(valid), 32'h0);
    in_data = 8'h11; in_eof = 1'b1;
    @(negedge clock);
    check("eof_release_valid", 32'(valid), 32'h1);
    check("eof_release_val", 32'(val_in), 32'h0);
    stb = '0; in_eof = 1'b0;
    @(negedge clock);
`else
    stb = S_RI; in_eof = 1'b1; n = 0;
    repeat (10) begin
      @(negedge clock);
      if (valid) n++;
    end
    check("eof_ignored_no_valid", 32'(n), 32'd0);
    in_valid = 1'b1; in_data = 8'h33;
    @(negedge clock);
    check("eof_ignored_valid", 32'(valid), 32'h1);
    check("eof_ignored_val", 32'(val_in), 32'h33);
    stb = '0; in_valid = 1'b0; in_eof = 1'b0;
    @(negedge clock);
`endif

    // Protocol error: multiple strobes, no side effects, sticky flag.
    req(S_RD, 8'd7, 8'h00, rv, lat);
    check("pre_proto_read", 32'(rv), 32'h41);
    @(negedge clock);
    req(S_RD | S_WI, 8'd7, 8'hEE, rv, lat);
    check("proto_latency", 32'(lat), 32'd1);
    check("proto_val_in", 32'(rv), 32'h0);
    check("proto_flag", 32'(proto_err), 32'h1);
    @(negedge clock);
    check("proto_fifo_unchanged", 32'(out_valid), 32'h0);
    req(S_WD | S_RI, 8'd7, 8'hEE, rv, lat);
    check("proto2_latency", 32'(lat), 32'd1);
    @(negedge clock);
    req(S_RD, 8'd7, 8'h00, rv, lat);
    check("proto_mem_unchanged", 32'(rv), 32'h41);
    check("proto_sticky", 32'(proto_err), 32'h1);
    @(negedge clock);

    // Reset mid-sweep at count 10 restarts the full clear.
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_busy", 32'(busy), 32'h1);
    check("midrst_proto_cleared", 32'(proto_err), 32'h0);
    reset = 1'b0;
    run_clear(1'b0, 1'b1, n, vseen);
    check("clear2_busy_cycles", 32'(n), 32'd256);
    check("clear2_strobe_ignored", 32'(vseen), 32'h0);
    req(S_RD, 8'd7, 8'h00, rv, lat);
    check("clear2_addr7", 32'(rv), 32'h0);
    @(negedge clock);
    req(S_RD, 8'd255, 8'h00, rv, lat);
    check("clear2_addr255", 32'(rv), 32'h0);
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bf_bus_responder.md
Name: bf_bus_responder

Overview:
- Target side of the BF interpreter bus: services the core's one-hot access strobes (read_prog, read_data, write_data, read_io, write_io) against program memory, data memory and a byte-stream I/O port.
- Drives the core's val_in and the completion pulse `valid`.
- Owns the post-reset data-memory clear sweep and the output byte FIFO.
- Sits between the BF core and the chip's memories/UART glue.

Parameters:
- ADDR_WIDTH, 15, bus address width; both memories have 2**ADDR_WIDTH entries.
- DATA_WIDTH, 8, bus/cell/byte width.
- OUT_FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- clock  input  1  single clock
- reset  input  1  asynchronous, active-high reset
- addr  input  ADDR_WIDTH  core address
- val_out  input  DATA_WIDTH  core write data
- val_in  output  DATA_WIDTH  read data to core
- valid  output  1  one-cycle completion pulse for the current request
- read_prog, read_data, write_data, read_io, write_io  input  1 each  core strobes
- busy  output  1  clear sweep in progress
- proto_err  output  1  sticky: more than one strobe was high in one cycle
- prog_we  input  1  program-load write enable
- prog_waddr  input  ADDR_WIDTH  program-load address
- prog_wdata  input  DATA_WIDTH  program-load data
- in_valid  input  1  input byte available
- in_data  input  DATA_WIDTH  input byte
- in_ready  output  1  input byte consumed this cycle
- out_valid  output  1  output FIFO non-empty
- out_data  output  DATA_WIDTH  FIFO head byte
- out_ready  input  1  sink accepts head byte
- in_eof  input  1  input stream exhausted (used only with the optional feature)

Behaviour:
- Reset values: val_in=0, valid=0, busy=1, proto_err=0, in_ready=0, out_valid=0. State=Clear, clear counter=0, FIFO empty.
- FSM states: Clear, Idle, Access, WaitIn, WaitOut.
- Clear: writes 0 to data address clear_cnt each cycle; after the last address goes to Idle and drops busy. Strobes are ignored in Clear (valid stays 0). Reset during Clear restarts the sweep at address 0.
- Request rule: the core holds its strobe, addr and val_out stable until it samples valid=1. A request is accepted only in Idle, and exactly one valid pulse is produced per request.
- Idle with exactly one strobe high → Access. In Access:
  - read_prog / read_data: synchronous memory read launched at acceptance; val_in = mem[addr] with valid=1 in the cycle after acceptance (latency 1).
  - write_data: writes mem[addr]=val_out at acceptance; valid=1 next cycle; val_in unchanged.
  - read_io: if in_valid, in_ready=1 for one cycle, val_in=in_data, valid=1. Otherwise → WaitIn; hold there until in_valid, then do the same.
  - write_io: if FIFO not full, push val_out and valid=1. Otherwise → WaitOut until a pop frees a slot, then push and valid=1.
  - After valid, return to Idle. The strobe being still high in the valid cycle is not a new request; a new request is recognised from the cycle after valid.
- More than one strobe high in Idle: no memory/IO side effect, proto_err set (sticky until reset), val_in=0, valid=1 next cycle.
- Program load: prog_we writes program memory any cycle, including Clear. If it hits the same address as a read_prog in the same cycle, the read returns the old value.
- FIFO: simultaneous push and pop when full is allowed (occupancy unchanged). Pointers wrap modulo OUT_FIFO_DEPTH.
- Memory sizes: data and program memories are internal, 2**ADDR_WIDTH × DATA_WIDTH each. Addresses wrap naturally, with no range check.

Optional Feature:
- Macro: BFCHIP_IO_EOF_EN.
- Defined: read_io while in_valid=0 and in_eof=1 completes immediately with val_in=0, valid=1 and no in_ready. in_eof asserting while in WaitIn releases the wait the same way.
- Undefined: in_eof is ignored, and read_io waits indefinitely for in_valid.

Decomposition:
- Package bf_bus_pkg holds:
  - the state enum type `resp_state_t` (Clear, Idle, Access, WaitIn, WaitOut);
  - the `req_kind_t` enum (ReqNone, ReqProg, ReqDataRd, ReqDataWr, ReqIoRd, ReqIoWr, ReqMulti);
  - the default width constants.
- One sub-module: bf_out_fifo (parameterised depth/width; push/full, pop/empty, registered head).

Test Plan:
- Reset, then count cycles → busy high for exactly 2**ADDR_WIDTH cycles. Afterwards read_data at 0, 5 and max address → val_in=0 and valid one cycle after acceptance.
- prog_we loads "+" (0x2B) at address 3, then read_prog addr=3 → val_in=0x2B next cycle. A same-cycle load and read of address 3 returns the old byte.
- write_data addr=7 val_out=0x41, then read_data addr=7 → 0x41. Reset asserted mid-Clear at count 10 → sweep restarts at 0 and busy stays high for the full duration.
- out_ready=0 with five write_io of 0x01..0x05 (depth 4) → four valids, the fifth stalls. Raising out_ready → bytes 0x01..0x05 emerge in order, and the fifth valid pulses after the first pop.
- read_io with in_valid=0 → no valid for 20 cycles. in_valid=1 with in_data=0x7A → in_ready pulses once, val_in=0x7A, valid=1. With BFCHIP_IO_EOF_EN defined and in_eof=1 → immediate val_in=0.
- read_data and write_io high together → proto_err=1, valid=1 with val_in=0, memory and FIFO unchanged. proto_err stays 1 after subsequent legal requests.
